// File: rtl/seq_scan_arbiter_if.sv
// ---------------------------------------------------------------------------
// seq_scan_arbiter_if
// Bundles the requester-facing signals of the scan arbiter.
//   req       : NREQ     request per requester, held until its gnt is seen
//   data      : NREQ*DW  requester i word at [i*DW +: DW]
//   gnt       : NREQ     one-hot, one-cycle capture acknowledge
//   busy      : 1        arbiter is not idle
//   bit_out   : 1        bit currently being scanned (MSB first)
//   bit_vld   : 1        bit_out is valid (every shift cycle)
//   hit       : 1        pattern detector sits in its final state
//   done      : 1        one-cycle result-valid pulse
//   done_id   : IW       requester index of the reported result
//   match_cnt : 4        non-overlapping "1001" matches in the word
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface seq_scan_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               bit_out;
  logic               bit_vld;
  logic               hit;
  logic               done;
  logic [IW-1:0]      done_id;
  logic [3:0]         match_cnt;

  modport master (
    output req, data,
    input  gnt, busy, bit_out, bit_vld, hit, done, done_id, match_cnt
  );

  modport slave (
    input  req, data,
    output gnt, busy, bit_out, bit_vld, hit, done, done_id, match_cnt
  );
endinterface

// File: rtl/seq_scan_arbiter.sv
// ---------------------------------------------------------------------------
// seq_scan_arbiter
// Round-robin arbiter that captures one requester's word, scans it out
// MSB first, counts non-overlapping "1001" patterns and reports the result.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : seq_scan_arbiter_if.slave (req/data in; gnt, busy, bit_out,
//          bit_vld, hit, done, done_id, match_cnt out)
// ---------------------------------------------------------------------------
module seq_scan_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_scan_arbiter_if.slave    bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
  typedef enum logic [2:0] {D0, D1, D2, D3, D4} det_t;

  state_t         state;
  det_t           det;
  det_t           det_next;
  logic [DW-1:0]  sr;
  logic [CW-1:0]  bit_cnt;
  logic [IW-1:0]  last_grant;
  logic [IW-1:0]  done_id_r;
  logic [NREQ-1:0] gnt_r;
  logic [3:0]     match_r;
  logic           busy_r;
  logic           vld_r;
  logic           done_r;
  logic           hit_r;

  logic           win_found;
  logic [IW-1:0]  win_id;
  logic           cur_bit;

  assign cur_bit = sr[DW-1];

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && bus.req[(int'(last_grant) + 1 + k) % NREQ]) begin
        win_found = 1'b1;
        win_id    = IW'((int'(last_grant) + 1 + k) % NREQ);
      end
    end
  end

  // "1001" detector; D4 restarts from scratch so matches never overlap.
  always_comb begin
    det_next = det;
    case (det)
      D0:      det_next = cur_bit ? D1 : D0;
      D1:      det_next = cur_bit ? D1 : D2;
      D2:      det_next = cur_bit ? D1 : D3;
      D3:      det_next = cur_bit ? D4 : D0;
      D4:      det_next = cur_bit ? D1 : D0;
      default: det_next = D0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      det        <= D0;
      sr         <= '0;
      bit_cnt    <= '0;
      last_grant <= IW'(NREQ - 1);
      done_id_r  <= '0;
      gnt_r      <= '0;
      match_r    <= '0;
      busy_r     <= 1'b0;
      vld_r      <= 1'b0;
      done_r     <= 1'b0;
      hit_r      <= 1'b0;
    end else begin
      // gnt and done are single-cycle pulses by default.
      gnt_r  <= '0;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            sr         <= bus.data[win_id*DW +: DW];
            det        <= D0;
            hit_r      <= 1'b0;
            match_r    <= '0;
            bit_cnt    <= '0;
            last_grant <= win_id;
            done_id_r  <= win_id;
            gnt_r      <= NREQ'(1) << win_id;
            busy_r     <= 1'b1;
            vld_r      <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          sr      <= {sr[DW-2:0], 1'b0};
          det     <= det_next;
          hit_r   <= (det_next == D4);
          bit_cnt <= bit_cnt + 1'b1;
          if (det_next == D4) begin
            match_r <= match_r + 4'd1;
          end
          if (bit_cnt == CW'(DW - 1)) begin
            vld_r  <= 1'b0;
            done_r <= 1'b1;
            state  <= REPORT;
          end
        end
        REPORT: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          vld_r  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.busy      = busy_r;
  assign bus.bit_out   = cur_bit;
  assign bus.bit_vld   = vld_r;
  assign bus.hit       = hit_r;
  assign bus.done      = done_r;
  assign bus.done_id   = done_id_r;
  assign bus.match_cnt = match_r;
endmodule

// File: tb/tb_seq_scan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seq_scan_arbiter
// Directed bench: expected transactions are queued as stimulus is driven and
// checked by a monitor when the arbiter reports each result.
// ---------------------------------------------------------------------------
module tb_seq_scan_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IW   = 2;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] word;
    logic [3:0]    cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_scan_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  seq_scan_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_seen = 0;
  logic [IW-1:0] last_id = '0;
  logic [3:0]    last_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Non-overlapping greedy substring count of 1001, scanning MSB first.
  function automatic logic [3:0] ref_count(input logic [DW-1:0] w);
    int i;
    logic [3:0] n;
    i = DW - 1;
    n = '0;
    while (i >= 3) begin
      if (w[i] && !w[i-1] && !w[i-2] && w[i-3]) begin
        n = n + 4'd1;
        i = i - 4;
      end else begin
        i = i - 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t mk(input int id, input logic [DW-1:0] w);
    exp_t e;
    e.id   = IW'(id);
    e.word = w;
    e.cnt  = ref_count(w);
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: collects scanned bits and checks each reported result.
  initial begin
    logic [DW-1:0] got_bits;
    int nbits;
    int gnt_cyc;
    logic hit_seen;
    exp_t e;
    got_bits = '0;
    nbits = 0;
    gnt_cyc = 0;
    hit_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.gnt != '0) begin
          if (sb.size() == 0) chk("gnt_unexpected", 64'(bus.gnt), 64'd0);
          else chk("gnt_onehot", 64'(bus.gnt), 64'(1) << sb[0].id);
          got_bits = '0;
          nbits = 0;
          hit_seen = 1'b0;
          gnt_cyc = cyc;
        end
        if (bus.bit_vld) begin
          got_bits = {got_bits[DW-2:0], bus.bit_out};
          nbits++;
        end
        if (bus.hit) hit_seen = 1'b1;
        if (bus.done) begin
          done_seen++;
          if (sb.size() == 0) begin
            chk("done_unexpected", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            $display("txn id=%0d word=%02h done_id=%0d match_cnt=%0d", e.id, e.word,
                     bus.done_id, bus.match_cnt);
            chk("done_id", 64'(bus.done_id), 64'(e.id));
            chk("match_cnt", 64'(bus.match_cnt), 64'(e.cnt));
            chk("scan_bits", 64'(got_bits), 64'(e.word));
            chk("scan_len", 64'(nbits), 64'(DW));
            chk("done_latency", 64'(cyc - gnt_cyc), 64'(DW));
            chk("hit_seen", 64'(hit_seen), 64'(e.cnt != 0));
            last_id = e.id;
            last_cnt = e.cnt;
          end
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk(tag, 64'({bus.gnt, bus.busy, bus.bit_out, bus.bit_vld, bus.hit, bus.done,
                  bus.done_id, bus.match_cnt}), 64'd0);
  endtask

  task automatic wait_gnt(output int c);
    int k;
    c = -1;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("gnt_timeout", 64'd1, 64'd0);
  endtask

  // Waits for the scoreboard to drain, then checks result hold one cycle on.
  task automatic wait_done();
    int k;
    for (k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
    chk("done_pulse_len", 64'(bus.done), 64'd0);
    chk("hold_done_id", 64'(bus.done_id), 64'(last_id));
    chk("hold_match_cnt", 64'(bus.match_cnt), 64'(last_cnt));
  endtask

  task automatic do_single(input int id, input logic [DW-1:0] w);
    bus.data[id*DW +: DW] = w;
    bus.req = NREQ'(1) << id;
    sb.push_back(mk(id, w));
    @(negedge clk);
    chk("gnt_latency", 64'(bus.gnt), 64'(1) << id);
    bus.req = '0;
    wait_done();
  endtask

  initial begin
    int c;
    int prev;
    int d;
    int rid;
    logic [DW-1:0] w;
    logic [IW-1:0] order [5];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    // Reset with every requester asking, then round-robin with req held.
    bus.req = 4'b1111;
    bus.data = {8'b1001_0011, 8'h00, 8'b0100_1001, 8'b1001_1001};
    for (int i = 0; i < 5; i++) sb.push_back(mk(order[i], bus.data[order[i]*DW +: DW]));
    repeat (3) begin
      @(negedge clk);
      chk_zero("reset_outputs");
    end
    rst = 1'b1;
    @(negedge clk);
    chk("gnt_after_reset", 64'(bus.gnt), 64'd1);
    prev = cyc;
    for (int i = 1; i < 5; i++) begin
      wait_gnt(c);
      chk("rr_gnt", 64'(bus.gnt), 64'(1) << order[i]);
      chk("rr_spacing", 64'(c - prev), 64'(DW + 2));
      prev = c;
    end
    bus.req = '0;
    wait_done();

    // Directed words on single requesters.
    do_single(0, 8'b1001_1001);
    do_single(0, 8'b0100_1001);
    do_single(2, 8'h00);

    // Abort mid-scan with reset during the 4th shift cycle.
    bus.data[0 +: DW] = 8'hFF;
    bus.req = 4'b0001;
    sb.push_back(mk(0, 8'hFF));
    @(negedge clk);
    chk("abort_gnt", 64'(bus.gnt), 64'd1);
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk("abort_in_shift", 64'(bus.bit_vld), 64'd1);
    d = done_seen;
    rst = 1'b0;
    sb.delete();
    #1;
    chk_zero("abort_reset_outputs");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 64'(done_seen), 64'(d));
    do_single(1, 8'b1001_1001);

    // A handful of pseudo-random words on random requesters.
    for (int i = 0; i < 6; i++) begin
      rid = int'($urandom_range(0, NREQ - 1));
      w = DW'($urandom);
      do_single(rid, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_scan_arbiter.md
SEQ_SCAN_ARBITER -- requirements
Module: seq_scan_arbiter

Interface
REQ-001 Parameter NREQ, 4: number of requesters sharing the scan channel (2..8).
REQ-002 Parameter DW, 8: word width, bits serialized per transaction (4..60).
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  NREQ  request per requester; held high until its gnt is seen.
REQ-006 Port data  input  NREQ*DW  requester i word at bits [i*DW +: DW]; held stable while req[i] is high.
REQ-007 Port gnt  output  NREQ  registered one-hot, one-cycle capture acknowledge.
REQ-008 Port busy  output  1  high whenever state is not IDLE.
REQ-009 Port bit_out  output  1  serialized bit currently being scanned, MSB first.
REQ-010 Port bit_vld  output  1  high on every SHIFT cycle.
REQ-011 Port hit  output  1  Moore detector output, high while the detector is in D4.
REQ-012 Port done  output  1  one-cycle pulse marking result valid.
REQ-013 Port done_id  output  $clog2(NREQ)  index of the requester whose result is reported.
REQ-014 Port match_cnt  output  4  count of non-overlapping "1001" matches in the word.

Function
REQ-015 The control FSM SHALL have states IDLE, SHIFT and REPORT.
REQ-016 IDLE: with any req bit high at a clock edge, the block SHALL capture the winner's word into the shift register, clear the detector to D0, clear the match counter, and enter SHIFT; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NREQ and the first high req wins; last_grant SHALL update on each capture.
REQ-018 gnt[winner] SHALL be high for exactly the first SHIFT cycle; every other gnt bit SHALL be 0.
REQ-019 SHIFT SHALL last exactly DW cycles: bit_out = shift register MSB and bit_vld = 1, with a left shift at each edge.
REQ-020 The detector SHALL step once per SHIFT edge on bit_out with states D0..D4:
- D0: 1->D1, 0->D0.
- D1: 0->D2, 1->D1.
- D2: 0->D3, 1->D1.
- D3: 1->D4, 0->D0.
- D4: 1->D1, 0->D0 (non-overlapping).
REQ-021 match_cnt SHALL increment by 1 on each SHIFT edge where the detector next-state is D4, including the final bit.
REQ-022 After the DW-th SHIFT cycle the FSM SHALL enter REPORT for exactly one cycle with done=1, done_id=captured index and match_cnt final; it then returns to IDLE.
REQ-023 done_id and match_cnt SHALL hold their values until the next capture.
REQ-024 Latency: req sampled at edge of cycle T -> gnt in T+1 -> bits in T+1..T+DW -> done in T+DW+1 -> earliest next gnt in T+DW+3.
REQ-025 req/data changes during SHIFT or REPORT SHALL be ignored; the captured word is used.
REQ-026 A req that drops before being granted SHALL simply be skipped.
REQ-027 An all-zero word SHALL still produce a done pulse with match_cnt=0.

Reset
REQ-028 rst low SHALL immediately force:
- state IDLE and detector D0;
- gnt, busy, bit_out, bit_vld, hit, done, done_id and match_cnt to 0;
- shift register to 0;
- last_grant to NREQ-1, so requester 0 has first priority.
REQ-029 Reset asserted mid-SHIFT SHALL abort the transaction with no done pulse.

Verification
REQ-030 Reset with req=4'b1111 held -> all outputs 0 while rst=0; after release gnt=4'b0001 one cycle later.
REQ-031 req=4'b0001, data0=8'b1001_1001 at T -> gnt=0001 at T+1; bit_out 1,0,0,1,1,0,0,1 over T+1..T+8; done=1, done_id=0, match_cnt=2 at T+9.
REQ-032 data0=8'b0100_1001 -> match_cnt=1; an overlapping detector would report 2, which is a fail.
REQ-033 req=4'b1111 held continuously -> gnt order 0,1,2,3,0, spaced DW+2=10 cycles apart; done_id follows the same order.
REQ-034 rst pulsed low during the 4th SHIFT cycle, then req=4'b0010 -> no done for the aborted word; gnt=4'b0010 and done_id=1 for the new word.
REQ-035 data=8'h00 -> done pulses with match_cnt=0 and hit never asserted.
